// File: rtl/rpc_server19.sv
// rpc_server19 -- single-client RPC execution unit.
//
// A client raises req with opcode/arg0/arg1; the server latches the call,
// executes it (one cycle for ALU/accumulator ops, WIDTH shift-add cycles for
// multiply), raises ack with result/err and holds them until req drops.
//
// Ports:
//   clk        : clock, all state updates on the rising edge
//   reset      : asynchronous active-high reset
//   req        : call request (four-phase handshake)
//   opcode     : 0 ADD, 1 SUB, 2 MUL, 3 ACC_ADD, 4 ACC_READ, 5 ACC_CLR, 6/7 illegal
//   arg0, arg1 : operands, sampled when the call is accepted
//   ack        : completion acknowledge
//   result     : return value, valid while ack is high, held afterwards
//   err        : illegal-opcode flag, valid while ack is high, held afterwards
//   busy       : high whenever the FSM is not in IDLE
//   call_count : completed calls, wraps modulo 2^CNTW
//
// State | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for req; latches the call on acceptance
// MUL   | shift-add multiply, one multiplier bit per cycle, WIDTH cycles
// EXEC  | writes result/err/acc, raises ack, counts the call
// ACK   | holds ack/result/err until req is sampled low

module rpc_server19 #(
  parameter int WIDTH = 32,
  parameter int CNTW  = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req,
  input  logic [2:0]       opcode,
  input  logic [WIDTH-1:0] arg0,
  input  logic [WIDTH-1:0] arg1,
  output logic             ack,
  output logic [WIDTH-1:0] result,
  output logic             err,
  output logic             busy,
  output logic [CNTW-1:0]  call_count
);

  localparam int MCW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    MUL  = 2'd2,
    ACK  = 2'd3
  } state_t;

  state_t           state;
  logic [2:0]       op_q;
  // opa/opb hold the latched operands; during MUL opa doubles as the
  // left-shifting multiplicand and opb as the right-shifting multiplier.
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic [WIDTH-1:0] prod;
  logic [WIDTH-1:0] acc;
  logic [MCW-1:0]   mul_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      op_q       <= '0;
      opa        <= '0;
      opb        <= '0;
      prod       <= '0;
      acc        <= '0;
      mul_cnt    <= '0;
      ack        <= 1'b0;
      result     <= '0;
      err        <= 1'b0;
      busy       <= 1'b0;
      call_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            op_q <= opcode;
            opa  <= arg0;
            opb  <= arg1;
            busy <= 1'b1;
            if (opcode == 3'd2) begin
              prod    <= '0;
              mul_cnt <= MCW'(WIDTH - 1);
              state   <= MUL;
            end else begin
              state <= EXEC;
            end
          end
        end

        MUL: begin
          if (opb[0]) prod <= prod + opa;
          opa <= opa << 1;
          opb <= opb >> 1;
          // Last multiplier bit is consumed on the edge that leaves MUL;
          // EXEC then publishes the finished product.
          if (mul_cnt == '0) begin
            state <= EXEC;
          end else begin
            mul_cnt <= mul_cnt - 1'b1;
          end
        end

        EXEC: begin
          err <= 1'b0;
          case (op_q)
            3'd0: result <= opa + opb;
            3'd1: result <= opa - opb;
            3'd2: result <= prod;
            3'd3: begin
              acc    <= acc + opa;
              result <= acc + opa;
            end
            3'd4: result <= acc;
            3'd5: begin
              acc    <= '0;
              result <= '0;
            end
            default: begin
              result <= '0;
              err    <= 1'b1;
            end
          endcase
          ack        <= 1'b1;
          call_count <= call_count + 1'b1;
          state      <= ACK;
        end

        ACK: begin
          if (!req) begin
            ack   <= 1'b0;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/rpc_server19.md
RPC_SERVER19 -- requirements
Module: rpc_server19

Interface
REQ-001 Parameter WIDTH, default 32, sets the width of the argument, result and accumulator datapaths.
REQ-002 Parameter CNTW, default 16, sets the width of the completed-call counter.
REQ-003 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 Port req, input, 1 bit: client call request, four-phase handshake.
REQ-006 Port opcode, input, 3 bits: operation select, stable while req is high.
REQ-007 Port arg0, input, WIDTH bits: first operand, stable while req is high.
REQ-008 Port arg1, input, WIDTH bits: second operand, stable while req is high.
REQ-009 Port ack, output, 1 bit: server completion acknowledge.
REQ-010 Port result, output, WIDTH bits: return value, valid whenever ack is high.
REQ-011 Port err, output, 1 bit: illegal-opcode flag, valid whenever ack is high.
REQ-012 Port busy, output, 1 bit: high in every state other than IDLE.
REQ-013 Port call_count, output, CNTW bits: number of completed calls, wraps modulo 2^CNTW.

Function
REQ-014 The FSM SHALL have exactly the states IDLE, EXEC, MUL and ACK.
REQ-015 In IDLE with req=1 at an edge, the block SHALL latch opcode/arg0/arg1 and go to MUL if opcode=2, else to EXEC.
REQ-016 In EXEC, the block SHALL compute result and err in one cycle, set ack=1 and go to ACK; ack is thus high 2 edges after req is sampled.
REQ-017 Opcode 0 ADD SHALL return (arg0+arg1) mod 2^WIDTH; opcode 1 SUB SHALL return (arg0-arg1) mod 2^WIDTH.
REQ-018 Opcode 2 MUL SHALL return the low WIDTH bits of arg0*arg1, computed by shift-add, one multiplier bit per cycle, for exactly WIDTH cycles in MUL; ack is high WIDTH+2 edges after req is sampled.
REQ-019 Opcode 3 ACC_ADD SHALL set acc=(acc+arg0) mod 2^WIDTH and return the new acc; opcode 4 ACC_READ SHALL return acc unchanged; opcode 5 ACC_CLR SHALL set acc=0 and return 0.
REQ-020 Opcodes 6 and 7 SHALL return result=0 with err=1 and leave acc unchanged; every legal opcode returns err=0.
REQ-021 In ACK, ack SHALL stay high and result/err SHALL stay stable until req is sampled 0; on that edge ack goes 0 and the FSM returns to IDLE.
REQ-022 call_count SHALL increment on the edge on which ack rises, including for illegal opcodes.
REQ-023 The block SHALL ignore req in EXEC and MUL, and changes to opcode/arg0/arg1 after latching SHALL not affect the result.
REQ-024 A req held high from one call into the next SHALL NOT start a second call; a new call needs req sampled 0 (the ACK exit) before it is sampled 1 again in IDLE.
REQ-025 result and err SHALL hold their last values after ack falls, until the next EXEC or MUL completion.

Reset
REQ-026 On reset=1, asynchronously: state=IDLE, ack=0, busy=0, err=0, result=0, acc=0, call_count=0, and the multiply registers are cleared.
REQ-027 Reset asserted during EXEC, MUL or ACK SHALL abort the call with no completion and no increment of call_count.
REQ-028 After reset deasserts, the first edge with req=1 SHALL start a call normally.

Verification
REQ-029 ADD: WIDTH=32, req with op0, 5, 7 -> ack rises 2 edges later, result=12, err=0, call_count=1.
REQ-030 SUB wrap: op1, arg0=3, arg1=5 -> result=0xFFFFFFFE; MUL: op2, 0x10000 x 0x10001 -> result=0x00010000, ack 34 edges after req.
REQ-031 Accumulator: ACC_ADD 10, ACC_ADD 0xFFFFFFFF, ACC_READ -> results 10, 9, 9; then ACC_CLR, ACC_READ -> 0, 0.
REQ-032 Illegal op7 -> result=0, err=1, acc unchanged, and call_count increments.
REQ-033 Handshake: hold req high for 10 cycles after ack -> ack stays high and no second call starts; drop req -> ack falls next edge; the next call runs normally.
REQ-034 Reset mid-MUL (cycle 10 of 32) -> ack=0, busy=0, call_count=0 immediately; a following ADD 1,1 returns 2.
